// File: rtl/icache_direct_pkg.sv
// Shared constants, FSM state encodings and address-field width helpers for the
// direct-mapped instruction cache.
package icache_direct_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_REFILL = 2'd1,
    ICACHE_DRAIN  = 2'd2
  } icache_state_e;

  // Tag width left over after word offset, line offset and index are removed.
  function automatic int tag_bits(input int lines, input int words);
    return 32 - $clog2(lines) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refill sequencing for icache_direct: issue counter, memory-latency delay line
// that tracks which word is arriving, and the line-complete flag.
module icache_refill_ctrl #(
  parameter int WORDS       = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_en,
  output logic [$clog2(WORDS)-1:0]   issue_idx,
  output logic                       issue_last,
  output logic                       cap_valid,
  output logic [$clog2(WORDS)-1:0]   cap_idx,
  output logic                       cap_last
);

  localparam int OFF_W = $clog2(WORDS);

  logic [OFF_W-1:0]       cnt_r;
  logic [MEM_LATENCY-1:0] dly_vld_r;
  logic [OFF_W-1:0]       dly_idx_r [MEM_LATENCY];

  // Issue counter wraps to zero after the last word, ready for the next refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (issue_en) begin
      cnt_r <= cnt_r + OFF_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Delay line mirrors the memory latency; reset drops any word still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_vld_r <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        dly_idx_r[i] <= '0;
      end
    end else begin
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        dly_vld_r[i] <= dly_vld_r[i-1];
        dly_idx_r[i] <= dly_idx_r[i-1];
      end
      dly_vld_r[0] <= issue_en;
      dly_idx_r[0] <= cnt_r;
    end
  end

  assign issue_idx  = cnt_r;
  assign issue_last = issue_en & (cnt_r == OFF_W'(WORDS - 1));
  assign cap_valid  = dly_vld_r[MEM_LATENCY-1];
  assign cap_idx    = dly_idx_r[MEM_LATENCY-1];
  assign cap_last   = cap_valid & (cap_idx == OFF_W'(WORDS - 1));

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with combinational hit path and
// whole-line refill. Optional hit/miss counters under ICACHE_PERF_EN.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int LINES       = 16,
  parameter int WORDS       = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_req,
  input  logic        invalidate,
  output logic [31:0] cpu_inst,
  output logic        icache_stall,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_bits(LINES, WORDS);
  localparam int LO_W  = OFF_W + 2;

  icache_state_e          state_r, next_state_s;
  logic [LINES-1:0]       valid_r;
  logic [TAG_W-1:0]       tag_r  [LINES];
  logic [31:0]            data_r [LINES][WORDS];
  logic [31-LO_W:0]       line_r;
  logic                   inv_pend_r;

  logic [OFF_W-1:0]       offset_s;
  logic [IDX_W-1:0]       index_s;
  logic [TAG_W-1:0]       tag_s;
  logic                   hit_s, miss_s;
  logic [IDX_W-1:0]       fill_idx_s;
  logic [TAG_W-1:0]       fill_tag_s;
  logic                   unused_s;

  logic                   issue_en_s, issue_last_s, cap_valid_s, cap_last_s;
  logic [OFF_W-1:0]       issue_idx_s, cap_idx_s;

  assign offset_s   = cpu_addr[LO_W-1:2];
  assign index_s    = cpu_addr[LO_W +: IDX_W];
  assign tag_s      = cpu_addr[LO_W+IDX_W +: TAG_W];
  assign hit_s      = cpu_req & valid_r[index_s] & (tag_r[index_s] == tag_s);
  assign miss_s     = cpu_req & ~hit_s;
  assign fill_idx_s = line_r[IDX_W-1:0];
  assign fill_tag_s = line_r[IDX_W +: TAG_W];
  assign issue_en_s = (state_r == ICACHE_REFILL);
  assign unused_s   = ^cpu_addr[1:0];

  icache_refill_ctrl #(
    .WORDS       (WORDS),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_refill_ctrl (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en_s),
    .issue_idx  (issue_idx_s),
    .issue_last (issue_last_s),
    .cap_valid  (cap_valid_s),
    .cap_idx    (cap_idx_s),
    .cap_last   (cap_last_s)
  );

  // Next state and outputs; reset forces the idle output values immediately.
  always_comb begin
    next_state_s = state_r;
    cpu_inst     = NOP_INST;
    icache_stall = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = 32'h0000_0000;
    if (rst) begin
      next_state_s = ICACHE_IDLE;
    end else begin
      case (state_r)
        ICACHE_IDLE: begin
          if (hit_s) begin
            cpu_inst = data_r[index_s][offset_s];
          end else if (cpu_req) begin
            icache_stall = 1'b1;
            next_state_s = ICACHE_REFILL;
          end else begin
            cpu_inst = NOP_INST;
          end
        end
        ICACHE_REFILL: begin
          icache_stall = 1'b1;
          mem_rd_en    = 1'b1;
          mem_addr     = {line_r, issue_idx_s, 2'b00};
          if (issue_last_s) begin
            next_state_s = ICACHE_DRAIN;
          end else begin
            next_state_s = ICACHE_REFILL;
          end
        end
        ICACHE_DRAIN: begin
          icache_stall = 1'b1;
          if (cap_last_s) begin
            next_state_s = ICACHE_IDLE;
          end else begin
            next_state_s = ICACHE_DRAIN;
          end
        end
        default: begin
          next_state_s = ICACHE_IDLE;
        end
      endcase
    end
  end

  // State, valid bits and latched line; an invalidate seen mid-refill is held
  // and applied on completion so the just-filled line is dropped too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ICACHE_IDLE;
      valid_r    <= '0;
      line_r     <= '0;
      inv_pend_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ICACHE_IDLE) begin
        if (invalidate) valid_r <= '0;
        if (miss_s) line_r <= cpu_addr[31:LO_W];
        inv_pend_r <= 1'b0;
      end else if (cap_last_s) begin
        if (inv_pend_r | invalidate) begin
          valid_r <= '0;
        end else begin
          valid_r[fill_idx_s] <= 1'b1;
        end
        inv_pend_r <= 1'b0;
      end else begin
        inv_pend_r <= inv_pend_r | invalidate;
      end
    end
  end

  // Line storage; contents are only trusted once the valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && cap_valid_s) begin
      data_r[fill_idx_s][cap_idx_s] <= mem_rdata;
      if (cap_last_s) tag_r[fill_idx_s] <= fill_tag_s;
    end
  end

`ifdef ICACHE_PERF_EN
  // Saturating hit/miss counters, untouched by invalidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits   <= 32'h0000_0000;
      perf_misses <= 32'h0000_0000;
    end else if (state_r == ICACHE_IDLE) begin
      if (hit_s && (perf_hits != 32'hFFFF_FFFF)) perf_hits <= perf_hits + 32'd1;
      if (miss_s && (perf_misses != 32'hFFFF_FFFF)) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: cache-level reference model checked every cycle on the
// default build, plus directed fetches on a MEM_LATENCY=3 instance.
module tb_icache_direct;

  localparam int W = 4;
  localparam int L = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, cpu_req, invalidate, icache_stall, mem_rd_en;
  logic [31:0] cpu_addr, cpu_inst, mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_req3, invalidate3, icache_stall3, mem_rd_en3;
  logic [31:0] cpu_addr3, cpu_inst3, mem_addr3;
  logic [31:0] mem_rdata3 = 32'h0;

  int checks = 0;
  int passes = 0;

  logic [31:0] addrs[$];
  logic [31:0] s1, s3;
  logic [31:0] pipe3 [3];

  bit          m_valid [16];
  logic [31:0] m_line  [16];
  int          m_busy = 0;
  bit          m_pend = 0;
  logic [31:0] m_fill;
  int          m_idx, m_k;
  bit          m_hit;

  int          nst, nrd;
  logic [31:0] inst;

  always #5 clk = ~clk;

  icache_direct dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
    .invalidate(invalidate), .cpu_inst(cpu_inst), .icache_stall(icache_stall),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  icache_direct #(.LINES(16), .WORDS(4), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr3), .cpu_req(cpu_req3),
    .invalidate(invalidate3), .cpu_inst(cpu_inst3), .icache_stall(icache_stall3),
    .mem_addr(mem_addr3), .mem_rd_en(mem_rd_en3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory: address seen in cycle c returns its word during cycle c+latency.
  always begin
    @(negedge clk);
    s1 = mem_addr;
    s3 = mem_addr3;
    @(posedge clk);
    #1;
    mem_rdata = mem_word(s1);
    pipe3[2] = pipe3[1];
    pipe3[1] = pipe3[0];
    pipe3[0] = mem_word(s3);
    mem_rdata3 = pipe3[2];
  end

  // Reference model: a miss blocks the cache for W+L further cycles, issuing the
  // line's words in its first W of them; a hit returns the memory word.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stall", {31'd0, icache_stall}, 32'd0);
      chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_inst", cpu_inst, NOP);
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_busy = 0;
      m_pend = 1'b0;
    end else if (m_busy == 0) begin
      m_idx = int'(cpu_addr[7:4]);
      m_hit = cpu_req && m_valid[m_idx] && (m_line[m_idx] == (cpu_addr >> 4));
      chk("idle_rd_en", {31'd0, mem_rd_en}, 32'd0);
      if (m_hit) begin
        chk("hit_inst", cpu_inst, mem_word(cpu_addr));
        chk("hit_stall", {31'd0, icache_stall}, 32'd0);
      end else if (cpu_req) begin
        chk("miss_stall", {31'd0, icache_stall}, 32'd1);
        chk("miss_inst", cpu_inst, NOP);
        m_busy = W + L;
        m_fill = cpu_addr >> 4;
        m_pend = 1'b0;
      end else begin
        chk("idle_stall", {31'd0, icache_stall}, 32'd0);
        chk("idle_inst", cpu_inst, NOP);
      end
      if (invalidate) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else begin
      m_k = W + L - m_busy;
      chk("busy_stall", {31'd0, icache_stall}, 32'd1);
      chk("busy_inst", cpu_inst, NOP);
      if (m_k < W) begin
        chk("refill_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("refill_addr", mem_addr, (m_fill << 4) + 32'(4 * m_k));
      end else begin
        chk("drain_rd_en", {31'd0, mem_rd_en}, 32'd0);
      end
      if (invalidate) m_pend = 1'b1;
      m_busy--;
      if (m_busy == 0) begin
        if (m_pend) begin
          for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else begin
          m_valid[int'(m_fill[3:0])] = 1'b1;
          m_line[int'(m_fill[3:0])]  = m_fill;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a fetch until served; optionally pulse invalidate in stall cycle inv_at.
  task automatic fetch(input logic [31:0] a, input int inv_at,
                       output int ns, output logic [31:0] ins, output int nr);
    bit done = 1'b0;
    ns = 0; nr = 0; ins = 32'h0;
    addrs.delete();
    cpu_req = 1'b1;
    cpu_addr = a;
    for (int i = 0; i < 40; i++) begin
      invalidate = (i == inv_at);
      @(negedge clk);
      if (mem_rd_en) begin
        nr++;
        addrs.push_back(mem_addr);
      end
      if (!icache_stall) begin
        done = 1'b1;
        ins = cpu_inst;
      end else begin
        ns++;
      end
      step(1);
      if (done) break;
    end
    invalidate = 1'b0;
    cpu_req = 1'b0;
    chk("fetch_served", {31'd0, done}, 32'd1);
  endtask

  task automatic fetch3(input logic [31:0] a, output int ns, output logic [31:0] ins);
    bit done = 1'b0;
    ns = 0; ins = 32'h0;
    addrs.delete();
    cpu_req3 = 1'b1;
    cpu_addr3 = a;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_rd_en3) addrs.push_back(mem_addr3);
      if (!icache_stall3) begin
        done = 1'b1;
        ins = cpu_inst3;
      end else begin
        ns++;
      end
      step(1);
      if (done) break;
    end
    cpu_req3 = 1'b0;
    chk("fetch3_served", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0; invalidate = 1'b0;
    cpu_req3 = 1'b0; cpu_addr3 = 32'h0; invalidate3 = 1'b0;
    step(2);
    rst = 1'b0;
    cpu_addr = 32'h14;
    step(1);

    // Cold miss, then hits on the rest of the line
    fetch(32'h10, -1, nst, inst, nrd);
    chk("cold_stalls", 32'(nst), 32'd6);
    chk("cold_inst", inst, 32'h1000_0004);
    chk("cold_nrd", 32'(addrs.size()), 32'd4);
    if (addrs.size() == 4) begin
      chk("cold_addr0", addrs[0], 32'h10);
      chk("cold_addr1", addrs[1], 32'h14);
      chk("cold_addr2", addrs[2], 32'h18);
      chk("cold_addr3", addrs[3], 32'h1C);
    end
    for (int i = 1; i < 4; i++) begin
      fetch(32'h10 + 32'(4 * i), -1, nst, inst, nrd);
      chk("hit_stalls", 32'(nst), 32'd0);
      chk("hit_word", inst, 32'h1000_0004 + 32'(i));
      chk("hit_nrd", 32'(nrd), 32'd0);
    end

    // Conflict eviction on index 1
    fetch(32'h110, -1, nst, inst, nrd);
    chk("conflict_stalls", 32'(nst), 32'd6);
    chk("conflict_inst", inst, 32'h1000_0044);
    fetch(32'h10, -1, nst, inst, nrd);
    chk("refetch_stalls", 32'(nst), 32'd6);

    // Invalidate mid-refill: line completes, then misses again
    fetch(32'h20, 3, nst, inst, nrd);
    chk("inv_refill_stalls", 32'(nst), 32'd12);
    chk("inv_refill_nrd", 32'(nrd), 32'd8);
    chk("inv_refill_inst", inst, 32'h1000_0008);

    // Invalidate together with a hit: the hit is still served
    cpu_req = 1'b1; cpu_addr = 32'h24; invalidate = 1'b1;
    @(negedge clk);
    chk("inv_hit_inst", cpu_inst, 32'h1000_0009);
    chk("inv_hit_stall", {31'd0, icache_stall}, 32'd0);
    step(1);
    invalidate = 1'b0; cpu_req = 1'b0;
    fetch(32'h24, -1, nst, inst, nrd);
    chk("after_inv_stalls", 32'(nst), 32'd6);

    // Reset in the middle of a refill
    fetch(32'h10, -1, nst, inst, nrd);
    chk("revalidate_stalls", 32'(nst), 32'd6);
    cpu_req = 1'b1; cpu_addr = 32'h30;
    step(3);
    rst = 1'b1; cpu_req = 1'b0;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, icache_stall}, 32'd0);
    chk("post_rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("post_rst_inst", cpu_inst, NOP);
    step(1);
    fetch(32'h10, -1, nst, inst, nrd);
    chk("post_rst_miss_stalls", 32'(nst), 32'd6);
    chk("post_rst_miss_inst", inst, 32'h1000_0004);

    // MEM_LATENCY=3 instance
    fetch3(32'h10, nst, inst);
    chk("lat3_stalls", 32'(nst), 32'd8);
    chk("lat3_inst", inst, 32'h1000_0004);
    chk("lat3_nrd", 32'(addrs.size()), 32'd4);
    if (addrs.size() == 4) begin
      chk("lat3_addr0", addrs[0], 32'h10);
      chk("lat3_addr3", addrs[3], 32'h1C);
    end
    fetch3(32'h1C, nst, inst);
    chk("lat3_hit_stalls", 32'(nst), 32'd0);
    chk("lat3_hit_inst", inst, 32'h1000_0007);

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
